// File: rtl/prbs6_checker.sv
// Self-synchronising checker for the x^6 + x^5 + 1 PRBS stream.
// Fills history, hunts for a clean run, then counts mismatches while locked.
module prbs6_checker #(
    parameter int unsigned LOCK_COUNT  = 12,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W  = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT)  : 1;
    localparam int unsigned WIN_W  = (WINDOW      > 1) ? $clog2(WINDOW)      : 1;
    localparam int unsigned WERR_W = (UNLOCK_ERRS > 1) ? $clog2(UNLOCK_ERRS) : 1;

    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_COUNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(UNLOCK_ERRS - 1);

    typedef enum logic [1:0] {
        FILL,
        HUNT,
        LOCKED
    } state_t;

    state_t            state, state_nx;
    logic [5:0]        h, h_nx, shifted;
    logic [2:0]        fill_cnt, fill_nx;
    logic [RUN_W-1:0]  run_cnt, run_nx;
    logic [WIN_W-1:0]  win_cnt, win_nx;
    logic [WERR_W-1:0] win_err, werr_nx;
    logic              exp_bit, mismatch, counted;
    logic              locked_nx;
    logic [CNT_W-1:0]  count_nx;

    assign exp_bit  = h[5] ^ h[4];
    assign shifted  = {h[4:0], in_bit};
    // An all-zero history can never come from the generator, so it is an error.
    assign mismatch = (in_bit != exp_bit) || (shifted == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            h         <= '0;
            fill_cnt  <= '0;
            run_cnt   <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            h         <= h_nx;
            fill_cnt  <= fill_nx;
            run_cnt   <= run_nx;
            win_cnt   <= win_nx;
            win_err   <= werr_nx;
            locked    <= locked_nx;
            err_pulse <= counted;
            err_count <= count_nx;
        end
    end

    always_comb begin
        state_nx = state;
        h_nx     = h;
        fill_nx  = fill_cnt;
        run_nx   = run_cnt;
        win_nx   = win_cnt;
        werr_nx  = win_err;
        counted  = 1'b0;
        if (in_valid) begin
            h_nx = shifted;
            case (state)
                FILL: begin
                    fill_nx = fill_cnt + 3'd1;
                    if (fill_cnt == 3'd5) begin
                        state_nx = HUNT;
                        run_nx   = '0;
                    end
                end
                HUNT: begin
                    if (mismatch) begin
                        run_nx = '0;
                    end else if (run_cnt == RUN_LAST) begin
                        state_nx = LOCKED;
                        run_nx   = '0;
                        win_nx   = '0;
                        werr_nx  = '0;
                    end else begin
                        run_nx = run_cnt + RUN_W'(1);
                    end
                end
                LOCKED: begin
                    counted = mismatch;
                    win_nx  = (win_cnt == WIN_LAST) ? '0 : win_cnt + WIN_W'(1);
                    // The window-closing bit still belongs to the closing window.
                    if (mismatch && (win_err == WERR_LAST)) begin
                        state_nx = HUNT;
                        run_nx   = '0;
                    end else if (win_cnt == WIN_LAST) begin
                        werr_nx = '0;
                    end else if (mismatch) begin
                        werr_nx = win_err + WERR_W'(1);
                    end
                end
                default: state_nx = FILL;
            endcase
        end
    end

    always_comb begin
        locked_nx = (state_nx == LOCKED);
        count_nx  = err_count;
        if (err_clr) begin
            count_nx = CNT_W'(counted);
        end else if (counted && (err_count != '1)) begin
            count_nx = err_count + CNT_W'(1);
        end
    end

endmodule
